// File: rtl/reg_access_pkg.sv
// Shared types and helpers for the Master-to-channel register access initiator.
package reg_access_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned BUS_W      = 32;

  // One-hot state encoding; strobes decode directly from these bits.
  typedef enum logic [6:0] {
    ST_IDLE  = 7'b000_0001,
    ST_LOAD  = 7'b000_0010,
    ST_CHECK = 7'b000_0100,
    ST_WRITE = 7'b000_1000,
    ST_READ  = 7'b001_0000,
    ST_WAIT  = 7'b010_0000,
    ST_RESP  = 7'b100_0000
  } state_t;

  // Captured request payload held for the duration of one access.
  typedef struct packed {
    logic             write;
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] wdata;
  } req_t;

  // Register numbers are legal only when everything above the low 5 bits is zero.
  function automatic logic addr_legal(input logic [BUS_W-1:0] addr);
    return addr[BUS_W-1:REG_ADDR_W] == '0;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc, stick at all-ones.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reg_access_master.sv
// Turns single register requests into load/read/write strobe sequences on the
// channel register bus and returns a response with read data or an error.
module reg_access_master
  import reg_access_pkg::*;
#(
  parameter int unsigned RD_LATENCY     = 1,
  parameter bit          SKIP_ADDR_LOAD = 1'b1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [31:0]      bus_data,
  output logic             bus_reg_num_le,
  output logic             bus_wr_en,
  output logic             bus_rd_en,
  input  logic [31:0]      bus_rdata,
  input  logic             bus_illegal,
  input  logic             flush_cache,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned WAIT_W = 3;

  state_t                  state;
  state_t                  state_nxt;
  req_t                    req_q;
  logic [WAIT_W-1:0]       wait_cnt;
  logic                    cache_vld;
  logic [REG_ADDR_W-1:0]   cache_addr;
  logic [BUS_W-1:0]        rdata_q;
  logic                    err_q;
  logic                    cache_hit_c;
  logic                    rsp_done_c;

  // A flush in the accept cycle forces a miss; illegal numbers never match.
  assign cache_hit_c = SKIP_ADDR_LOAD && cache_vld && !flush_cache &&
                       addr_legal(req_addr) &&
                       (req_addr[REG_ADDR_W-1:0] == cache_addr);

  assign rsp_done_c = (state == ST_RESP) && rsp_ready;

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_nxt      = state;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    bus_reg_num_le = 1'b0;
    bus_wr_en      = 1'b0;
    bus_rd_en      = 1'b0;
    bus_data       = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (cache_hit_c) begin
            state_nxt = req_write ? ST_WRITE : ST_READ;
          end else begin
            state_nxt = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        bus_reg_num_le = 1'b1;
        bus_data       = req_q.addr;
        state_nxt      = ST_CHECK;
      end
      ST_CHECK: begin
        if (bus_illegal) begin
          state_nxt = ST_RESP;
        end else begin
          state_nxt = req_q.write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        bus_wr_en = 1'b1;
        bus_data  = req_q.wdata;
        state_nxt = ST_RESP;
      end
      ST_READ: begin
        bus_rd_en = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt == WAIT_W'(1)) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, address cache, read-wait counter and response data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_q      <= '0;
      wait_cnt   <= '0;
      cache_vld  <= 1'b0;
      cache_addr <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (flush_cache) begin
        cache_vld <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_q.write <= req_write;
            req_q.addr  <= req_addr;
            req_q.wdata <= req_wdata;
          end
        end
        ST_CHECK: begin
          if (bus_illegal) begin
            err_q <= 1'b1;
          end else if (!flush_cache) begin
            cache_vld  <= 1'b1;
            cache_addr <= req_q.addr[REG_ADDR_W-1:0];
          end
        end
        ST_READ: begin
          wait_cnt <= WAIT_W'(RD_LATENCY);
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - WAIT_W'(1);
          if (wait_cnt == WAIT_W'(1)) begin
            rdata_q <= bus_rdata;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Completed-access counters, one per outcome.
  sat_counter #(.CNT_W(CNT_W)) u_wr_cnt (
    .clk   (clk),
    .clear (!reset_n),
    .inc   (rsp_done_c && !err_q && req_q.write),
    .count (wr_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_rd_cnt (
    .clk   (clk),
    .clear (!reset_n),
    .inc   (rsp_done_c && !err_q && !req_q.write),
    .count (rd_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .clear (!reset_n),
    .inc   (rsp_done_c && err_q),
    .count (err_count)
  );

endmodule

// File: tb/tb_reg_access_master.sv
// Randomised and directed bench for reg_access_master with a channel stub and
// a transaction-level reference model.
module tb_reg_access_master;

  localparam int unsigned RD_LAT = 1;
  localparam int unsigned CW     = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [31:0]   bus_data;
  logic          bus_reg_num_le;
  logic          bus_wr_en;
  logic          bus_rd_en;
  logic [31:0]   bus_rdata;
  logic          bus_illegal;
  logic          flush_cache;
  logic [CW-1:0] wr_count;
  logic [CW-1:0] rd_count;
  logic [CW-1:0] err_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  reg_access_master #(
    .RD_LATENCY     (RD_LAT),
    .SKIP_ADDR_LOAD (1'b1),
    .CNT_W          (CW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .bus_data       (bus_data),
    .bus_reg_num_le (bus_reg_num_le),
    .bus_wr_en      (bus_wr_en),
    .bus_rd_en      (bus_rd_en),
    .bus_rdata      (bus_rdata),
    .bus_illegal    (bus_illegal),
    .flush_cache    (flush_cache),
    .wr_count       (wr_count),
    .rd_count       (rd_count),
    .err_count      (err_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Channel stub: illegal numbers are flagged and not loaded.
  logic [31:0] ch_mem [32];
  logic [4:0]  ch_reg   = '0;
  logic        ch_ill   = 1'b0;
  logic [31:0] ch_rdata = '0;
  assign bus_illegal = ch_ill;
  assign bus_rdata   = ch_rdata;

  always @(posedge clk) begin
    if (bus_wr_en) ch_mem[ch_reg] = bus_data;
    if (bus_rd_en) ch_rdata <= ch_mem[ch_reg];
    if (bus_reg_num_le) begin
      ch_ill <= (bus_data > 32'd31);
      if (bus_data <= 32'd31) ch_reg <= bus_data[4:0];
    end
  end

  // Reference model: schedule of one access computed from its accept cycle.
  logic [31:0] ref_mem [32];
  bit          model_on = 1'b0;
  bit          m_busy, m_hit, m_wr, m_ill, m_cvld;
  int          m_acc, m_strobe, m_rsp;
  logic [31:0] m_addr, m_wdata, m_rdata, m_caddr;
  logic [CW-1:0] m_wrc, m_rdc, m_errc;
  bit          e_ready, e_le, e_wr, e_rd, e_rv;
  logic [31:0] e_data;

  // Per-transaction observation used by the directed literal checks.
  int          obs_acc, obs_le, obs_wr, obs_rd, obs_rsp;
  logic [31:0] obs_le_data, obs_wr_data, obs_rdata;
  logic        obs_err;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  always @(negedge clk) begin
    if (model_on) begin
      e_ready = !m_busy;
      e_le    = m_busy && !m_hit && (cyc == m_acc + 1);
      e_wr    = m_busy && !m_ill && m_wr && (cyc == m_strobe);
      e_rd    = m_busy && !m_ill && !m_wr && (cyc == m_strobe);
      e_rv    = m_busy && (cyc >= m_rsp);
      e_data  = e_le ? m_addr : (e_wr ? m_wdata : 32'd0);
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("bus_reg_num_le", 32'(bus_reg_num_le), 32'(e_le));
      chk("bus_wr_en", 32'(bus_wr_en), 32'(e_wr));
      chk("bus_rd_en", 32'(bus_rd_en), 32'(e_rd));
      chk("bus_data", bus_data, e_data);
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      if (e_rv) begin
        chk("rsp_rdata", rsp_rdata, (m_wr || m_ill) ? 32'd0 : m_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(m_ill));
      end
      chk("wr_count", 32'(wr_count), 32'(m_wrc));
      chk("rd_count", 32'(rd_count), 32'(m_rdc));
      chk("err_count", 32'(err_count), 32'(m_errc));
    end

    if (bus_reg_num_le && obs_le < 0) begin obs_le = cyc - obs_acc; obs_le_data = bus_data; end
    if (bus_wr_en && obs_wr < 0) begin obs_wr = cyc - obs_acc; obs_wr_data = bus_data; end
    if (bus_rd_en && obs_rd < 0) obs_rd = cyc - obs_acc;
    if (rsp_valid && obs_rsp < 0) begin obs_rsp = cyc - obs_acc; obs_rdata = rsp_rdata; obs_err = rsp_err; end
    if (reset_n && req_valid && req_ready) begin
      obs_acc = cyc; obs_le = -1; obs_wr = -1; obs_rd = -1; obs_rsp = -1;
    end

    if (model_on && m_busy && m_wr && !m_ill && cyc == m_strobe) ref_mem[m_addr[4:0]] = m_wdata;
    if (!reset_n) begin
      model_on = 1'b1; m_busy = 1'b0; m_cvld = 1'b0;
      m_wrc = '0; m_rdc = '0; m_errc = '0;
    end else if (model_on) begin
      if (m_busy) begin
        if (cyc >= m_rsp && rsp_ready) begin
          if (m_ill) m_errc = sat_inc(m_errc);
          else if (m_wr) m_wrc = sat_inc(m_wrc);
          else m_rdc = sat_inc(m_rdc);
          m_busy = 1'b0;
        end else if (!m_hit && !m_ill && cyc == m_acc + 2 && !flush_cache) begin
          m_cvld = 1'b1; m_caddr = m_addr;
        end
      end else if (req_valid) begin
        m_busy   = 1'b1;
        m_acc    = cyc;
        m_addr   = req_addr;
        m_wdata  = req_wdata;
        m_wr     = req_write;
        m_ill    = (req_addr > 32'd31);
        m_hit    = m_cvld && !flush_cache && (req_addr == m_caddr);
        m_rdata  = ref_mem[req_addr[4:0]];
        m_strobe = m_hit ? m_acc + 1 : m_acc + 3;
        m_rsp    = m_ill ? m_acc + 3 : (m_wr ? m_strobe + 1 : m_strobe + 1 + int'(RD_LAT));
      end
      if (flush_cache) m_cvld = 1'b0;
    end
  end

  bit rand_mode = 1'b0;

  // Issue one request (called just after a rising edge) and wait until idle again.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic fl);
    int n;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; flush_cache = fl;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0; flush_cache = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    n = 0;
    while (!req_ready && n < 200) begin
      if (rand_mode) begin
        rsp_ready   = ($urandom_range(0, 3) != 0);
        flush_cache = ($urandom_range(0, 19) == 0);
        reset_n     = ($urandom_range(0, 249) != 0);
      end
      @(posedge clk); #1; n++;
    end
    chk("completion_timeout", 32'(req_ready), 32'd1);
    reset_n = 1'b1; flush_cache = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] a;
    for (int i = 0; i < 32; i++) begin
      ch_mem[i]  = 32'hA500_0000 | 32'(i);
      ref_mem[i] = 32'hA500_0000 | 32'(i);
    end
    ch_mem[31]  = 32'h0001_0203;
    ref_mem[31] = 32'h0001_0203;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; flush_cache = 1'b0;
    repeat (3) @(posedge clk);
    #1; reset_n = 1'b1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_bus_data", bus_data, 32'd0);
    chk("reset_wr_count", 32'(wr_count), 32'd0);

    // Write miss then read-back hit
    do_req(1'b1, 32'h0E, 32'h5, 1'b0);
    chk("wr_le_cycle", obs_le, 1);
    chk("wr_le_data", obs_le_data, 32'h0E);
    chk("wr_strobe_cycle", obs_wr, 3);
    chk("wr_strobe_data", obs_wr_data, 32'h5);
    chk("wr_rsp_cycle", obs_rsp, 4);
    chk("wr_rsp_err", 32'(obs_err), 32'd0);
    chk("wr_count_1", 32'(wr_count), 32'd1);
    do_req(1'b0, 32'h0E, 32'h0, 1'b0);
    chk("rb_no_le", obs_le, -1);
    chk("rb_rd_cycle", obs_rd, 1);
    chk("rb_rsp_cycle", obs_rsp, 3);
    chk("rb_rdata", obs_rdata, 32'h5);

    // Read miss of register 31
    do_req(1'b0, 32'h1F, 32'h0, 1'b0);
    chk("rd31_rd_cycle", obs_rd, 3);
    chk("rd31_rsp_cycle", obs_rsp, 5);
    chk("rd31_rdata", obs_rdata, 32'h0001_0203);

    // Illegal register number, twice
    do_req(1'b0, 32'h20, 32'h0, 1'b0);
    chk("ill_le_cycle", obs_le, 1);
    chk("ill_no_wr", obs_wr, -1);
    chk("ill_no_rd", obs_rd, -1);
    chk("ill_rsp_cycle", obs_rsp, 3);
    chk("ill_err", 32'(obs_err), 32'd1);
    chk("ill_rdata", obs_rdata, 32'd0);
    chk("err_count_1", 32'(err_count), 32'd1);
    do_req(1'b0, 32'h20, 32'h0, 1'b0);
    chk("ill2_le_cycle", obs_le, 1);
    chk("err_count_2", 32'(err_count), 32'd2);

    // Cache hit, flush pulse, flush at accept
    do_req(1'b0, 32'h07, 32'h0, 1'b0);
    chk("r7a_rsp_cycle", obs_rsp, 5);
    do_req(1'b0, 32'h07, 32'h0, 1'b0);
    chk("r7b_no_le", obs_le, -1);
    chk("r7b_rsp_cycle", obs_rsp, 3);
    chk("r7b_rdata", obs_rdata, 32'hA500_0007);
    flush_cache = 1'b1; @(posedge clk); #1; flush_cache = 1'b0;
    do_req(1'b0, 32'h07, 32'h0, 1'b0);
    chk("r7c_le_cycle", obs_le, 1);
    do_req(1'b0, 32'h07, 32'h0, 1'b1);
    chk("r7d_le_cycle", obs_le, 1);
    chk("rd_count_6", 32'(rd_count), 32'd6);

    // Response backpressure
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h07;
    @(posedge clk); #1; req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    repeat (10) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, 32'hA500_0007);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rd_count", 32'(rd_count), 32'd6);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rd_count_after", 32'(rd_count), 32'd7);
    chk("bp_req_ready_after", 32'(req_ready), 32'd1);
    chk("bp_no_le", obs_le, -1);

    // Reset during the read wait
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h05;
    @(posedge clk); #1; req_valid = 1'b0;
    n = 0;
    while (!bus_rd_en && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_le", 32'(bus_reg_num_le), 32'd0);
    chk("rst_wr", 32'(bus_wr_en), 32'd0);
    chk("rst_rd", 32'(bus_rd_en), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rd_count", 32'(rd_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    reset_n = 1'b1;
    do_req(1'b0, 32'h05, 32'h0, 1'b0);
    chk("post_rst_le", obs_le, 1);
    chk("post_rst_rdata", obs_rdata, 32'hA500_0005);
    chk("post_rst_rd_count", 32'(rd_count), 32'd1);

    // Randomised traffic
    rand_mode = 1'b1;
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: a = 32'($urandom_range(0, 7));
        7: a = 32'($urandom_range(0, 31));
        8: a = 32'd32 + 32'($urandom_range(0, 3));
        default: a = $urandom;
      endcase
      do_req(1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) begin
        flush_cache = ($urandom_range(0, 9) == 0);
        @(posedge clk); #1;
      end
      flush_cache = 1'b0;
    end
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
